// File: rtl/prog_mem_loader.sv
// 64x8 unified program/data memory with a zero-fill sweep and a byte-stream
// program loader that holds the processor in reset until the program is in.
module prog_mem_loader #(
   parameter int AW    = 6,
   parameter int DW    = 8,
   parameter int DEPTH = 2**AW
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          load_valid,
   input  logic [DW-1:0] load_data,
   input  logic          load_last,
   output logic          load_ready,
   input  logic          reload,
   input  logic [AW-1:0] cpu_addr,
   input  logic          cpu_we,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_rst_n,
   output logic [1:0]    state,
   output logic [AW:0]   words_loaded
);

   typedef enum logic [1:0] {
      CLEAR = 2'b00,
      LOAD  = 2'b01,
      RUN   = 2'b10
   } state_t;

   state_t        state_q, state_nxt;
   logic [AW-1:0] ptr_q, ptr_nxt;
   logic [AW:0]   wl_q, wl_nxt;

   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= CLEAR;
         ptr_q   <= '0;
         wl_q    <= '0;
      end else begin
         state_q <= state_nxt;
         ptr_q   <= ptr_nxt;
         wl_q    <= wl_nxt;
      end
   end

   // Loader handshake: a byte transfers on a posedge where load_valid and
   // load_ready are both high; load_last is only meaningful on such a beat.
   // reload wins over everything, so ready drops and CPU writes are dropped.
   always_comb begin
      state_nxt  = state_q;
      ptr_nxt    = ptr_q;
      wl_nxt     = wl_q;
      mem_we     = 1'b0;
      mem_waddr  = ptr_q;
      mem_wdata  = '0;
      load_ready = 1'b0;
      if (reload) begin
         state_nxt = CLEAR;
         ptr_nxt   = '0;
         wl_nxt    = '0;
      end else begin
         case (state_q)
            CLEAR: begin
               mem_we  = 1'b1;
               ptr_nxt = ptr_q + 1'b1;
               if (ptr_q == AW'(DEPTH-1)) begin
                  ptr_nxt   = '0;
                  state_nxt = LOAD;
               end
            end
            LOAD: begin
               load_ready = 1'b1;
               if (load_valid) begin
                  mem_we    = 1'b1;
                  mem_wdata = load_data;
                  ptr_nxt   = ptr_q + 1'b1;
                  wl_nxt    = wl_q + 1'b1;
                  if (load_last || ptr_q == AW'(DEPTH-1)) begin
                     ptr_nxt   = '0;
                     state_nxt = RUN;
                  end
               end
            end
            RUN: begin
               if (cpu_we) begin
                  mem_we    = 1'b1;
                  mem_waddr = cpu_addr;
                  mem_wdata = cpu_wdata;
               end
            end
            default: state_nxt = CLEAR;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
   end

   // Zero-latency read: the processor samples data_in in the same cycle.
   assign cpu_rdata    = mem[cpu_addr];
   assign cpu_rst_n    = (state_q == RUN);
   assign state        = state_q;
   assign words_loaded = wl_q;

endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- 64x8 unified program/data memory with a byte-stream program loader.
- Sits directly on the processor's memory bus (addr, we, data_out in; data_in out).
- After reset it zero-fills memory, accepts a program over a valid/ready byte stream, then releases the processor's reset and serves its fetch, load and store accesses.

Parameters:
- AW, 6, address width; matches the processor's 6-bit address bus.
- DW, 8, data width.
- DEPTH, 2**AW, number of words.

Ports:
- clk  in  1  clock; all writes and state updates on posedge.
- clr_n  in  1  reset; asynchronous, active-low.
- load_valid  in  1  loader byte valid.
- load_data  in  DW  loader byte.
- load_last  in  1  marks the final byte of the program; qualified by load_valid.
- load_ready  out  1  loader can accept a byte this cycle.
- reload  in  1  single-cycle request to restart the clear/load sequence.
- cpu_addr  in  AW  processor memory address.
- cpu_we  in  1  processor write enable.
- cpu_wdata  in  DW  processor write data (its data_out).
- cpu_rdata  out  DW  read data to the processor (its data_in).
- cpu_rst_n  out  1  drives the processor's clr_n.
- state  out  2  CLEAR=00, LOAD=01, RUN=10.
- words_loaded  out  AW+1  count of accepted loader bytes, 0..DEPTH.

Behaviour:
- Reset (clr_n low, async): state=CLEAR, ptr=0, words_loaded=0, cpu_rst_n=0, load_ready=0. Array contents are not reset; the CLEAR sweep zeroes them.
- Read path: cpu_rdata = mem[cpu_addr], combinational, zero latency, in every state.
  - Required because the processor samples data_in on negedge within the same cycle its address changes.
  - During LOAD, a read of the address being written returns the old value until the posedge.
- cpu_rst_n: decoded from the state register; 1 only in RUN.
- CLEAR:
  - Each posedge writes 0 to mem[ptr] and increments ptr.
  - At the posedge where ptr==DEPTH-1: write, ptr<=0, state<=LOAD.
  - Duration is exactly DEPTH cycles. load_ready=0. cpu_we is ignored.
- LOAD:
  - load_ready = 1 while reload=0.
  - A beat is accepted on a posedge with load_valid & load_ready: mem[ptr]<=load_data, ptr<=ptr+1, words_loaded<=words_loaded+1.
  - No beat is accepted when load_valid=0; ptr holds. cpu_we is ignored.
  - An accepted beat with load_last=1, or an accepted beat with ptr==DEPTH-1, moves state to RUN on that posedge. ptr wraps to 0.
  - words_loaded never exceeds DEPTH; there is no overflow path.
- RUN:
  - load_ready=0; load_valid is ignored.
  - On each posedge with cpu_we=1: mem[cpu_addr]<=cpu_wdata.
  - words_loaded holds its value.
- reload:
  - In any state, reload=1 at a posedge sets state<=CLEAR, ptr<=0, words_loaded<=0.
  - reload has priority over a simultaneous load beat (load_ready is forced to 0 that cycle) and over a simultaneous CPU write (the write is dropped).
  - cpu_rst_n falls in the cycle after the reload posedge. The processor is held in reset for the full CLEAR+LOAD sequence.
- Write port: single, one write per cycle. The source is selected by state: CLEAR=zero, LOAD=loader, RUN=CPU.
- Stores to the word just fetched are permitted; the result is visible on the next read.
- Implementation: the state register and ptr use the clr_n async reset; the memory array is plain posedge writes.

Test Plan:
1. Release clr_n; hold load_valid=0 -> state=00 for exactly 64 cycles with load_ready=0 and cpu_rst_n=0; then state=01, load_ready=1; every cpu_addr 0..63 reads 0x00.
2. In LOAD, send 0x3F, 0x81, 0x00 with load_last on the third -> words_loaded=3; state=10 and cpu_rst_n=1 after the third posedge; cpu_addr=1 -> cpu_rdata=0x81; cpu_addr=3 -> 0x00.
3. Send 5 bytes with load_valid deasserted for 2 cycles between each -> ptr and words_loaded advance only on valid cycles; bytes land at addresses 0..4 with no gaps.
4. Send 64 bytes (value = address XOR 0xA5) with no load_last -> auto transition to RUN after the 64th; words_loaded=64; every address reads back its pattern.
5. In RUN, cpu_we=1, cpu_addr=0x2A, cpu_wdata=0x5C for one cycle -> cpu_rdata at 0x2A reads 0x5C next cycle. In LOAD, cpu_we=1 to address 0x10 -> mem[0x10] is unchanged.
6. Assert reload mid-LOAD (after 10 bytes, coinciding with a valid beat) -> beat not accepted, state=00, words_loaded=0, then 64-cycle CLEAR. Assert reload in RUN -> cpu_rst_n=0 the next cycle. Assert clr_n=0 mid-CLEAR -> state=00 and ptr=0 immediately, and the sweep restarts.
